// File: rtl/cmat_pkg.sv
// cmat_pkg: shared state type, width helpers and saturating add for the complex matrix MAC engine.
package cmat_pkg;
  typedef enum logic [2:0] {IDLE, FETCH, DRAIN, OUT, DONE} state_t;
  typedef logic signed [127:0] wide_t;
  typedef struct packed {
    wide_t sum;
    logic  ovf;
  } sat_t;
  function automatic int addr_w(input int dim);
    return dim > 1 ? $clog2(dim * dim) : 1;
  endfunction
  function automatic int idx_w(input int dim);
    return dim > 1 ? $clog2(dim) : 1;
  endfunction
  function automatic int shift_of(input int frac_in, input int frac_acc);
    return 2 * frac_in - frac_acc;
  endfunction
  // Clamps a + b to the signed range of a width-bit word.
  function automatic sat_t sat_add(input wide_t a, input wide_t b, input int width);
    wide_t s, hi, lo;
    sat_t r;
    s = a + b;
    hi = (wide_t'(1) <<< (width - 1)) - wide_t'(1);
    lo = -hi - wide_t'(1);
    r.sum = s > hi ? hi : s < lo ? lo : s;
    r.ovf = s > hi || s < lo;
    return r;
  endfunction
endpackage

// File: rtl/cmat_mac_seq_if.sv
// cmat_mac_seq_if: A/B read ports and C result handshake of the matrix MAC engine.
interface cmat_mac_seq_if import cmat_pkg::*; #(
  parameter int DIM = 3,
  parameter int WIDTH = 32,
  parameter int ACC_WIDTH = 32
) ();
  localparam int ADDR_W = addr_w(DIM);
  localparam int IDX_W = idx_w(DIM);
  logic [ADDR_W-1:0] a_addr, b_addr;
  logic signed [WIDTH-1:0] a_re, a_im, b_re, b_im;
  logic c_valid, c_ready;
  logic signed [ACC_WIDTH-1:0] c_re, c_im;
  logic [IDX_W-1:0] c_row, c_col;
  modport master (
    output a_addr, b_addr, c_valid, c_re, c_im, c_row, c_col,
    input  a_re, a_im, b_re, b_im, c_ready
  );
  modport slave (
    input  a_addr, b_addr, c_valid, c_re, c_im, c_row, c_col,
    output a_re, a_im, b_re, b_im, c_ready
  );
endinterface

// File: rtl/cmplx_mult_pipe.sv
// cmplx_mult_pipe: two-stage complex multiply (partial products, then combine) with optional conj(b).
module cmplx_mult_pipe #(
  parameter int WIDTH = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic conj,
  input  logic in_valid,
  input  logic in_first,
  input  logic signed [WIDTH-1:0] a_re,
  input  logic signed [WIDTH-1:0] a_im,
  input  logic signed [WIDTH-1:0] b_re,
  input  logic signed [WIDTH-1:0] b_im,
  output logic out_valid,
  output logic out_first,
  output logic signed [2*WIDTH:0] out_re,
  output logic signed [2*WIDTH:0] out_im
);
  localparam int PW = 2 * WIDTH;
  localparam int SW = PW + 1;
  logic signed [PW-1:0] p_rr, p_ii, p_ri, p_ir;
  logic p_valid, p_first;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      {p_rr, p_ii, p_ri, p_ir} <= '0;
      {p_valid, p_first, out_valid, out_first} <= '0;
      {out_re, out_im} <= '0;
    end else begin
      p_rr <= PW'(a_re) * PW'(b_re);
      p_ii <= PW'(a_im) * PW'(b_im);
      p_ri <= PW'(a_re) * PW'(b_im);
      p_ir <= PW'(a_im) * PW'(b_re);
      p_valid <= in_valid;
      p_first <= in_first;
      out_re <= conj ? SW'(p_rr) + SW'(p_ii) : SW'(p_rr) - SW'(p_ii);
      out_im <= conj ? SW'(p_ir) - SW'(p_ri) : SW'(p_ir) + SW'(p_ri);
      out_valid <= p_valid;
      out_first <= p_first;
    end
endmodule

// File: rtl/cmat_mac_seq.sv
// cmat_mac_seq: self-sequencing complex matrix multiply C = A x B or A x conj(B) with a saturating MAC.
module cmat_mac_seq import cmat_pkg::*; #(
  parameter int DIM = 3,
  parameter int WIDTH = 32,
  parameter int FRAC_IN = 27,
  parameter int ACC_WIDTH = 32,
  parameter int FRAC_ACC = 11
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic conj_b,
  output logic busy,
  output logic done,
  output logic ovf,
  cmat_mac_seq_if.master bus
);
  localparam int ADDR_W = addr_w(DIM);
  localparam int IDX_W = idx_w(DIM);
  localparam int SHIFT = shift_of(FRAC_IN, FRAC_ACC);
  localparam int SW = 2 * WIDTH + 1;
  state_t state;
  logic [IDX_W-1:0] i, j, k, ni, nj;
  logic [1:0] dcnt;
  logic conj, go, hs, last_k, last_j, last_e, dv, df, sv, sf;
  logic signed [SW-1:0] s_re, s_im;
  logic signed [ACC_WIDTH-1:0] acc_re, acc_im;
  sat_t tr, ti, rr, ri;
  assign go = state == IDLE && start;
  assign hs = state == OUT && bus.c_ready;
  assign last_k = k == IDX_W'(DIM - 1);
  assign last_j = j == IDX_W'(DIM - 1);
  assign last_e = last_j && i == IDX_W'(DIM - 1);
  assign ni = last_j ? i + IDX_W'(1) : i;
  assign nj = last_j ? '0 : j + IDX_W'(1);
  assign busy = state inside {FETCH, DRAIN, OUT};
  assign done = state == DONE;
  assign bus.c_valid = state == OUT;
  assign bus.c_re = acc_re;
  assign bus.c_im = acc_im;
  assign bus.c_row = i;
  assign bus.c_col = j;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      {i, j, k, dcnt, conj, dv, df} <= '0;
      bus.a_addr <= '0;
      bus.b_addr <= '0;
    end else begin
      dv <= state == FETCH;
      df <= state == FETCH && k == '0;
      case (state)
        IDLE: if (start) begin
          state <= FETCH;
          conj <= conj_b;
          {i, j, k} <= '0;
          bus.a_addr <= '0;
          bus.b_addr <= '0;
        end
        FETCH: begin
          k <= last_k ? '0 : k + IDX_W'(1);
          dcnt <= '0;
          if (last_k) state <= DRAIN;
          else begin
            bus.a_addr <= ADDR_W'(int'(i) * DIM + int'(k) + 1);
            bus.b_addr <= ADDR_W'((int'(k) + 1) * DIM + int'(j));
          end
        end
        DRAIN: begin
          dcnt <= dcnt + 2'd1;
          if (dcnt == 2'd2) state <= OUT;
        end
        OUT: if (hs) begin
          i <= ni;
          j <= nj;
          state <= last_e ? DONE : FETCH;
          if (!last_e) begin
            bus.a_addr <= ADDR_W'(int'(ni) * DIM);
            bus.b_addr <= ADDR_W'(nj);
          end
        end
        default: state <= IDLE;
      endcase
    end
  cmplx_mult_pipe #(.WIDTH(WIDTH)) u_mult (
    .clk(clk), .rst(rst), .conj(conj), .in_valid(dv), .in_first(df),
    .a_re(bus.a_re), .a_im(bus.a_im), .b_re(bus.b_re), .b_im(bus.b_im),
    .out_valid(sv), .out_first(sf), .out_re(s_re), .out_im(s_im)
  );
  // The shifted term is clamped on its own before joining the running sum.
  always_comb begin
    tr = sat_add(wide_t'(s_re >>> SHIFT), '0, ACC_WIDTH);
    ti = sat_add(wide_t'(s_im >>> SHIFT), '0, ACC_WIDTH);
    rr = sat_add(wide_t'(acc_re), tr.sum, ACC_WIDTH);
    ri = sat_add(wide_t'(acc_im), ti.sum, ACC_WIDTH);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      acc_re <= '0;
      acc_im <= '0;
      ovf <= 1'b0;
    end else if (go) ovf <= 1'b0;
    else if (sv) begin
      acc_re <= ACC_WIDTH'(sf ? tr.sum : rr.sum);
      acc_im <= ACC_WIDTH'(sf ? ti.sum : ri.sum);
      ovf <= ovf | tr.ovf | ti.ovf | (!sf & (rr.ovf | ri.ovf));
    end
endmodule

// File: tb/tb_cmat_mac_seq.sv
// tb_cmat_mac_seq: scoreboard bench for cmat_mac_seq (default, 20-bit accumulator and DIM=1 builds).
module tb_cmat_mac_seq;
  logic clk = 0, rst = 1;
  logic start0 = 0, conj0 = 0, start1 = 0, conj1 = 0, start2 = 0, conj2 = 0;
  logic busy0, done0, ovf0, busy1, done1, ovf1, busy2, done2, ovf2;
  int checks = 0, errors = 0, hs_cnt = 0, n_done = 0;
  bit pend_done = 0;
  typedef struct {longint re, im; int row, col;} exp_t;
  exp_t sb[$];
  logic signed [31:0] ar[16], ai[16], br[16], bi[16];

  always #5 clk = ~clk;

  cmat_mac_seq_if #(.DIM(3), .WIDTH(32), .ACC_WIDTH(32)) bus0 ();
  cmat_mac_seq_if #(.DIM(3), .WIDTH(32), .ACC_WIDTH(20)) bus1 ();
  cmat_mac_seq_if #(.DIM(1), .WIDTH(32), .ACC_WIDTH(32)) bus2 ();

  cmat_mac_seq #(.DIM(3)) u0 (.clk(clk), .rst(rst), .start(start0), .conj_b(conj0),
    .busy(busy0), .done(done0), .ovf(ovf0), .bus(bus0.master));
  cmat_mac_seq #(.DIM(3), .ACC_WIDTH(20)) u1 (.clk(clk), .rst(rst), .start(start1), .conj_b(conj1),
    .busy(busy1), .done(done1), .ovf(ovf1), .bus(bus1.master));
  cmat_mac_seq #(.DIM(1)) u2 (.clk(clk), .rst(rst), .start(start2), .conj_b(conj2),
    .busy(busy2), .done(done2), .ovf(ovf2), .bus(bus2.master));

  // Synchronous RAMs with one-cycle read latency for the main instance.
  always @(posedge clk) begin
    bus0.a_re <= ar[bus0.a_addr];
    bus0.a_im <= ai[bus0.a_addr];
    bus0.b_re <= br[bus0.b_addr];
    bus0.b_im <= bi[bus0.b_addr];
  end
  // Constant matrices: every element (8+j8) for u1; a=(2+j0), b=(3+j1) for u2.
  assign bus1.a_re = 32'sh4000_0000;
  assign bus1.a_im = 32'sh4000_0000;
  assign bus1.b_re = 32'sh4000_0000;
  assign bus1.b_im = 32'sh4000_0000;
  assign bus1.c_ready = 1'b1;
  assign bus2.a_re = 32'sh1000_0000;
  assign bus2.a_im = 32'sh0;
  assign bus2.b_re = 32'sh1800_0000;
  assign bus2.b_im = 32'sh0800_0000;
  assign bus2.c_ready = 1'b1;

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (pend_done) begin
      check("done_pulse", longint'(done0), 1);
      pend_done = 0;
    end
    if (bus0.c_valid && bus0.c_ready) begin
      hs_cnt++;
      check("sb_has_entry", longint'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("c_re", longint'(bus0.c_re), e.re);
        check("c_im", longint'(bus0.c_im), e.im);
        check("c_idx", {bus0.c_row, bus0.c_col}, longint'(e.row * 4 + e.col));
        if (sb.size() == 0) pend_done = 1;
      end
    end
    if (done0) n_done++;
  end

  task automatic fill_identity();
    for (int n = 0; n < 16; n++) begin
      ar[n] = (n == 0 || n == 4 || n == 8) ? 32'sh0800_0000 : 32'sh0;
      ai[n] = 0;
      br[n] = n < 9 ? n << 27 : 0;
      bi[n] = 32'sh0400_0000;
    end
  endtask

  task automatic push_identity();
    for (int n = 0; n < 9; n++) sb.push_back('{longint'(n) << 11, 64'h400, n / 3, n % 3});
  endtask

  task automatic fill_const(input logic signed [31:0] v);
    for (int n = 0; n < 16; n++) begin
      ar[n] = v; ai[n] = v; br[n] = v; bi[n] = v;
    end
  endtask

  task automatic fill_rand();
    for (int n = 0; n < 16; n++) begin
      ar[n] = int'($urandom_range(0, 1 << 30)) - (1 << 29);
      ai[n] = int'($urandom_range(0, 1 << 30)) - (1 << 29);
      br[n] = int'($urandom_range(0, 1 << 30)) - (1 << 29);
      bi[n] = int'($urandom_range(0, 1 << 30)) - (1 << 29);
    end
  endtask

  // Reference complex matmul; each term floored by 2*27-11 = 43 bits before summing.
  task automatic push_model(input bit cj);
    longint re, im, rr, ii, ri, ir;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        re = 0;
        im = 0;
        for (int k = 0; k < 3; k++) begin
          rr = longint'(ar[i*3+k]) * longint'(br[k*3+j]);
          ii = longint'(ai[i*3+k]) * longint'(bi[k*3+j]);
          ri = longint'(ar[i*3+k]) * longint'(bi[k*3+j]);
          ir = longint'(ai[i*3+k]) * longint'(br[k*3+j]);
          re += (cj ? rr + ii : rr - ii) >>> 43;
          im += (cj ? ir - ri : ir + ri) >>> 43;
        end
        sb.push_back('{re, im, i, j});
      end
  endtask

  task automatic go0(input bit cj, input int stall);
    int cyc;
    @(posedge clk); #1;
    start0 = 1;
    conj0 = cj;
    bus0.c_ready = (stall == 0);
    @(posedge clk); #1;
    start0 = 0;
    cyc = 1;
    check("busy_after_start", longint'(busy0), 1);
    while (!bus0.c_valid && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("first_valid_cycle", cyc, 7);
    for (int s = 0; s < stall; s++) begin
      check("stall_valid", longint'(bus0.c_valid), 1);
      check("stall_c", {bus0.c_re, bus0.c_im}, 64'h400);
      check("stall_idx", {bus0.c_row, bus0.c_col}, 0);
      check("stall_addr", {bus0.a_addr, bus0.b_addr}, 8'h26);
      @(posedge clk); #1;
    end
    bus0.c_ready = 1;
  endtask

  task automatic finish0();
    int cyc = 0;
    while ((sb.size() != 0 || busy0) && cyc < 500) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("run_finished", longint'(cyc < 500), 1);
    @(posedge clk); #1;
  endtask

  task automatic run0(input bit cj, input int stall);
    int hs0 = hs_cnt, nd0 = n_done;
    go0(cj, stall);
    finish0();
    check("result_count", hs_cnt - hs0, 9);
    check("done_count", n_done - nd0, 1);
    check("ovf_clear", longint'(ovf0), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int hs0, nd0, cyc, cnt;
    bus0.c_ready = 1;
    fill_identity();
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", {busy0, done0, ovf0, bus0.c_valid, bus0.a_addr, bus0.b_addr, bus0.c_row, bus0.c_col}, 0);
    check("rst_c", {bus0.c_re, bus0.c_im}, 0);
    rst = 0;
    // identity times B
    push_identity();
    run0(0, 0);
    // conjugate modes with all-(1+j1) matrices
    fill_const(32'sh0800_0000);
    for (int n = 0; n < 9; n++) sb.push_back('{64'h3000, 0, n / 3, n % 3});
    run0(1, 0);
    for (int n = 0; n < 9; n++) sb.push_back('{0, 64'h3000, n / 3, n % 3});
    run0(0, 0);
    // random data against the reference model, both modes
    fill_rand();
    push_model(0);
    run0(0, 0);
    push_model(1);
    run0(1, 0);
    // backpressure on element (0,0)
    fill_identity();
    push_identity();
    run0(0, 5);
    // start pulsed while busy is ignored
    push_identity();
    hs0 = hs_cnt;
    nd0 = n_done;
    go0(0, 0);
    cyc = 0;
    while (hs_cnt < hs0 + 3 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    start0 = 1;
    conj0 = 1;
    repeat (2) @(posedge clk);
    #1;
    start0 = 0;
    finish0();
    check("busy_start_count", hs_cnt - hs0, 9);
    check("busy_start_done", n_done - nd0, 1);
    // reset during FETCH of element (1,2)
    push_identity();
    hs0 = hs_cnt;
    nd0 = n_done;
    go0(0, 0);
    cyc = 0;
    while (hs_cnt < hs0 + 5 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    @(posedge clk); #1;
    check("fetch_addr", {bus0.a_addr, bus0.b_addr}, 8'h45);
    rst = 1;
    #1;
    check("abort_state", {busy0, done0, ovf0, bus0.c_valid, bus0.a_addr, bus0.b_addr, bus0.c_row, bus0.c_col}, 0);
    check("abort_c", {bus0.c_re, bus0.c_im}, 0);
    sb.delete();
    repeat (3) @(posedge clk);
    #1;
    rst = 0;
    check("abort_no_done", n_done - nd0, 0);
    push_identity();
    run0(0, 0);
    // saturation with a 20-bit accumulator
    for (int r = 0; r < 2; r++) begin
      @(posedge clk); #1;
      start1 = 1;
      conj1 = 1;
      @(posedge clk); #1;
      start1 = 0;
      if (r == 1) check("sat_ovf_cleared", longint'(ovf1), 0);
      cnt = 0;
      cyc = 0;
      while (!done1 && cyc < 200) begin
        if (bus1.c_valid) begin
          check("sat_re", longint'(bus1.c_re), 64'h7FFFF);
          check("sat_im", longint'(bus1.c_im), 0);
          cnt++;
        end
        @(posedge clk); #1;
        cyc++;
      end
      check("sat_done", longint'(done1), 1);
      check("sat_count", cnt, 9);
      check("sat_ovf", longint'(ovf1), 1);
    end
    // DIM=1 build
    @(posedge clk); #1;
    start2 = 1;
    @(posedge clk); #1;
    start2 = 0;
    cyc = 1;
    while (!bus2.c_valid && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("dim1_cycle", cyc, 5);
    check("dim1_re", longint'(bus2.c_re), 64'h3000);
    check("dim1_im", longint'(bus2.c_im), 64'h1000);
    @(posedge clk); #1;
    check("dim1_done", longint'(done2), 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
